// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b MAR/MDR memory subsystem.
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } mem_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  function automatic logic [15:0] sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// Byte-addressed RAM split into even/odd byte lanes, per-lane write enables, combinational read.
module lc3b_mem_array #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk_50,
  input  logic [ADDR_W-2:0] addr,
  input  logic              we_even,
  input  logic              we_odd,
  input  logic [7:0]        wdata_even,
  input  logic [7:0]        wdata_odd,
  output logic [7:0]        rd_even_c,
  output logic [7:0]        rd_odd_c
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W - 1);

  logic [7:0] lane_even [DEPTH];
  logic [7:0] lane_odd  [DEPTH];

  always_ff @(posedge clk_50) begin
    if (we_even) lane_even[addr] <= wdata_even;
    if (we_odd)  lane_odd[addr]  <= wdata_odd;
  end

  assign rd_even_c = lane_even[addr];
  assign rd_odd_c  = lane_odd[addr];

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// MAR/MDR memory controller with fixed read/write latency and byte/word access.
// Define MEM_ALIGN_CHECK_EN to add the ua_err output for misaligned word accesses.
module lc3b_mem_ctrl
  import lc3b_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned READ_LAT  = 5,
  parameter int unsigned WRITE_LAT = 10
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              rw,
  input  logic              datasize,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              r
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              ua_err
`endif
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  generate
    if (DATA_W != 16) begin : g_bad_data_w
      $error("lc3b_mem_ctrl: DATA_W must be 16");
    end
    if (READ_LAT < 1 || WRITE_LAT < 1) begin : g_bad_lat
      $error("lc3b_mem_ctrl: READ_LAT and WRITE_LAT must be >= 1");
    end
  endgenerate

  mem_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                rw_q, rw_d;
  logic                size_q, size_d;
  logic                r_d;
  logic                we_even_c, we_odd_c;
  logic [7:0]          wdata_odd_c;
  logic [7:0]          rd_even_c, rd_odd_c;
  logic [7:0]          rd_byte_c;
`ifdef MEM_ALIGN_CHECK_EN
  logic                ua_q, ua_d;
  logic                misaligned_c;
  assign misaligned_c = (size_q == SIZE_WORD) && mar_q[0];
`endif

  assign rd_byte_c   = mar_q[0] ? rd_odd_c : rd_even_c;
  // Byte writes to an odd address land the low MDR byte on the odd lane.
  assign wdata_odd_c = (size_q == SIZE_BYTE) ? mdr_q[7:0] : mdr_q[15:8];

  lc3b_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_50     (clk_50),
    .addr       (mar_q[ADDR_W-1:1]),
    .we_even    (we_even_c),
    .we_odd     (we_odd_c),
    .wdata_even (mdr_q[7:0]),
    .wdata_odd  (wdata_odd_c),
    .rd_even_c  (rd_even_c),
    .rd_odd_c   (rd_odd_c)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      rw_q    <= RW_READ;
      size_q  <= SIZE_WORD;
      r       <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      ua_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      r       <= r_d;
`ifdef MEM_ALIGN_CHECK_EN
      ua_q    <= ua_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    rw_d      = rw_q;
    size_d    = size_q;
    r_d       = 1'b0;
    we_even_c = 1'b0;
    we_odd_c  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    ua_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ld_mar) mar_d = bus_in[ADDR_W-1:0];
        if (ld_mdr) mdr_d = bus_in;
        if (mio_en) begin
          rw_d    = rw;
          size_d  = datasize;
          cnt_d   = (rw == RW_WRITE) ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          r_d     = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          ua_d    = misaligned_c;
          if (!misaligned_c) begin
`else
          begin
`endif
            if (rw_q == RW_WRITE) begin
              we_even_c = (size_q == SIZE_WORD) || !mar_q[0];
              we_odd_c  = (size_q == SIZE_WORD) || mar_q[0];
            end else if (size_q == SIZE_WORD) begin
              mdr_d = {rd_odd_c, rd_even_c};
            end else begin
              mdr_d = sext_byte(rd_byte_c);
            end
          end
        end
      end
      ST_DONE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!mio_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mar_out = mar_q;
  assign mdr_out = mdr_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign ua_err  = ua_q;
`endif

endmodule
